// File: rtl/p_ctrl_pkg.sv
// Shared FSM state type and default widths for the proportional duty controller.
package p_ctrl_pkg;

    localparam int DEF_DUTY_W   = 8;
    localparam int DEF_KP_W     = 4;
    localparam int DEF_KP_SHIFT = 2;
    localparam int DEF_PERIOD_W = 10;
    localparam int DEF_MAX_STEP = 16;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        CLAMP,
        WAIT_PERIOD,
        APPLY
    } ctrl_state_t;

endpackage

// File: rtl/duty_clamp.sv
// Combinational saturating add of a signed correction onto the current duty command.
// The optional per-update slew clamp is compiled in with P_DUTY_SLEW_LIMIT_EN.
module duty_clamp
    import p_ctrl_pkg::*;
#(
    parameter int DUTY_W   = DEF_DUTY_W,
    parameter int DELTA_W  = DEF_DUTY_W + DEF_KP_W + 2,
    parameter int MAX_STEP = DEF_MAX_STEP
) (
    input  logic        [DUTY_W-1:0]  cur_duty,
    input  logic signed [DELTA_W-1:0] delta,
    output logic        [DUTY_W-1:0]  result,
    output logic                      saturated
);

`ifdef P_DUTY_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    localparam int SUM_W = DELTA_W + 2;
    localparam logic signed [SUM_W-1:0]  MAX_VAL = SUM_W'((2 ** DUTY_W) - 1);
    localparam logic signed [DUTY_W:0]   STEP    = (DUTY_W + 1)'(MAX_STEP);

    logic signed [SUM_W-1:0] sum;
    logic signed [DUTY_W:0]  diff;
    logic        [DUTY_W-1:0] clipped;
    logic                    range_sat;

    // Range saturation first; the slew clamp then limits movement from the present duty.
    always_comb begin
        sum       = $signed({{(SUM_W - DUTY_W){1'b0}}, cur_duty})
                  + $signed({{2{delta[DELTA_W-1]}}, delta});
        clipped   = sum[DUTY_W-1:0];
        range_sat = 1'b0;
        if (sum < 0) begin
            clipped   = '0;
            range_sat = 1'b1;
        end else if (sum > MAX_VAL) begin
            clipped   = '1;
            range_sat = 1'b1;
        end

        diff      = $signed({1'b0, clipped}) - $signed({1'b0, cur_duty});
        result    = clipped;
        saturated = range_sat;
        if (SLEW_EN && (diff > STEP)) begin
            result    = cur_duty + DUTY_W'(MAX_STEP);
            saturated = 1'b1;
        end else if (SLEW_EN && (diff < -STEP)) begin
            result    = cur_duty - DUTY_W'(MAX_STEP);
            saturated = 1'b1;
        end
    end

endmodule

// File: rtl/p_duty_controller.sv
// Proportional duty-cycle controller: new duty commands take effect only at a PWM period
// boundary. Define P_DUTY_SLEW_LIMIT_EN to limit each update to +/-MAX_STEP.
module p_duty_controller
    import p_ctrl_pkg::*;
#(
    parameter int DUTY_W   = DEF_DUTY_W,
    parameter int KP_W     = DEF_KP_W,
    parameter int KP_SHIFT = DEF_KP_SHIFT,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int MAX_STEP = DEF_MAX_STEP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DUTY_W-1:0] setpoint,
    input  logic [DUTY_W-1:0] measurement,
    input  logic [KP_W-1:0]   kp,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_update,
    output logic              saturated
);

    localparam int PROD_W = DUTY_W + KP_W + 2;

    ctrl_state_t state, next_state;

    logic [PERIOD_W-1:0]      period_cnt;
    logic                     boundary;
    logic                     accept;
    logic [DUTY_W-1:0]        sp_q, meas_q;
    logic [KP_W-1:0]          kp_q;
    logic signed [DUTY_W:0]   error;
    logic signed [PROD_W-1:0] err_ext, kp_ext, product, product_q, delta;
    logic [DUTY_W-1:0]        cand_next, cand_q;
    logic                     cand_sat_next, cand_sat_q;

    assign boundary     = &period_cnt;
    assign sample_ready = reset_n && enable && (state == IDLE);
    assign accept       = sample_ready && sample_valid;

    assign error   = $signed({1'b0, sp_q}) - $signed({1'b0, meas_q});
    assign err_ext = PROD_W'(error);
    assign kp_ext  = PROD_W'({1'b0, kp_q});
    assign product = err_ext * kp_ext;
    assign delta   = product_q >>> KP_SHIFT;

    duty_clamp #(
        .DUTY_W   (DUTY_W),
        .DELTA_W  (PROD_W),
        .MAX_STEP (MAX_STEP)
    ) u_clamp (
        .cur_duty  (duty_cycle),
        .delta     (delta),
        .result    (cand_next),
        .saturated (cand_sat_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) period_cnt <= '0;
        else          period_cnt <= period_cnt + PERIOD_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Dropping enable abandons any in-flight update from every state.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:        if (accept) next_state = CALC;
                CALC:        next_state = CLAMP;
                CLAMP:       next_state = WAIT_PERIOD;
                WAIT_PERIOD: if (boundary) next_state = APPLY;
                APPLY:       next_state = IDLE;
                default:     next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q       <= '0;
            meas_q     <= '0;
            kp_q       <= '0;
            product_q  <= '0;
            cand_q     <= '0;
            cand_sat_q <= 1'b0;
        end else if (enable) begin
            if (accept) begin
                sp_q   <= setpoint;
                meas_q <= measurement;
                kp_q   <= kp;
            end
            if (state == CALC) product_q <= product;
            if (state == CLAMP) begin
                cand_q     <= cand_next;
                cand_sat_q <= cand_sat_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_cycle  <= '0;
            saturated   <= 1'b0;
            duty_update <= 1'b0;
        end else if (!enable) begin
            duty_cycle  <= '0;
            saturated   <= 1'b0;
            duty_update <= 1'b0;
        end else begin
            duty_update <= (state == APPLY);
            if (state == APPLY) begin
                duty_cycle <= cand_q;
                saturated  <= cand_sat_q;
            end
        end
    end

endmodule

// File: tb/tb_p_duty_controller.sv
// Self-checking bench for p_duty_controller: transaction-level reference model, directed
// cases with literal expectations, then randomized traffic. Honours P_DUTY_SLEW_LIMIT_EN.
module tb_p_duty_controller;

    localparam int DUTY_W   = 8;
    localparam int KP_W     = 4;
    localparam int KP_SHIFT = 2;
    localparam int PERIOD_W = 10;
    localparam int MAX_STEP = 16;
    localparam int PERIOD   = 1 << PERIOD_W;
    localparam int DUTY_MAX = (1 << DUTY_W) - 1;

    logic              clk          = 1'b0;
    logic              reset_n      = 1'b1;
    logic              enable       = 1'b0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic [DUTY_W-1:0] setpoint     = '0;
    logic [DUTY_W-1:0] measurement  = '0;
    logic [KP_W-1:0]   kp           = '0;
    logic [DUTY_W-1:0] duty_cycle;
    logic              duty_update;
    logic              saturated;

    int     checks    = 0;
    int     failures  = 0;
    int     upd_count = 0;

    // Reference model state: what the outputs must be after the latest clock edge.
    int     m_duty    = 0;
    bit     m_sat     = 1'b0;
    bit     m_upd     = 1'b0;
    bit     m_busy    = 1'b0;
    int     m_res     = 0;
    bit     m_rsat    = 1'b0;
    int     m_cnt     = 0;
    longint m_n       = 0;
    longint m_target  = 0;

    p_duty_controller #(
        .DUTY_W   (DUTY_W),
        .KP_W     (KP_W),
        .KP_SHIFT (KP_SHIFT),
        .PERIOD_W (PERIOD_W),
        .MAX_STEP (MAX_STEP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .setpoint     (setpoint),
        .measurement  (measurement),
        .kp           (kp),
        .duty_cycle   (duty_cycle),
        .duty_update  (duty_update),
        .saturated    (saturated)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
        end
    endtask

    // New duty from plain arithmetic: floor((sp-meas)*kp / 2^KP_SHIFT) added, then clipped.
    function automatic void predict(input int sp, input int me, input int k, input int cur,
                                    output int res, output bit sat);
        int v;
        v   = cur + (((sp - me) * k) >>> KP_SHIFT);
        sat = 1'b0;
        if (v < 0) begin
            v = 0; sat = 1'b1;
        end else if (v > DUTY_MAX) begin
            v = DUTY_MAX; sat = 1'b1;
        end
`ifdef P_DUTY_SLEW_LIMIT_EN
        if (v - cur > MAX_STEP) begin
            v = cur + MAX_STEP; sat = 1'b1;
        end else if (cur - v > MAX_STEP) begin
            v = cur - MAX_STEP; sat = 1'b1;
        end
`endif
        res = v;
    endfunction

    // Model: an accepted sample lands at the edge closing the cycle after the first
    // period boundary that falls at least three cycles after acceptance.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_duty = 0; m_sat = 1'b0; m_upd = 1'b0; m_busy = 1'b0; m_cnt = 0; m_n = 0;
        end else begin
            m_upd = 1'b0;
            if (!enable) begin
                m_busy = 1'b0; m_duty = 0; m_sat = 1'b0;
            end else if (m_busy && (m_n == m_target)) begin
                m_duty = m_res; m_sat = m_rsat; m_upd = 1'b1; m_busy = 1'b0;
            end else if (!m_busy && sample_valid) begin
                m_busy   = 1'b1;
                m_target = m_n + 4 + ((((PERIOD - 4 - m_cnt) % PERIOD) + PERIOD) % PERIOD);
                predict(int'(setpoint), int'(measurement), int'(kp), m_duty, m_res, m_rsat);
            end
            m_cnt = (m_cnt + 1) % PERIOD;
            m_n++;
        end
    end

    // Every cycle, compare all outputs against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        checkOutput("duty_cycle", int'(duty_cycle), m_duty);
        checkOutput("saturated", int'(saturated), int'(m_sat));
        checkOutput("duty_update", int'(duty_update), int'(m_upd));
        checkOutput("sample_ready", int'(sample_ready), int'(reset_n && enable && !m_busy));
        if (duty_update) upd_count++;
    end

    task automatic applyStimulus(input int sp, input int me, input int k);
        int t;
        @(negedge clk);
        #1;
        setpoint     = DUTY_W'(sp);
        measurement  = DUTY_W'(me);
        kp           = KP_W'(k);
        sample_valid = 1'b1;
        t = 0;
        while (!m_busy && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        sample_valid = 1'b0;
        if (!m_busy) begin
            checks++; failures++;
            $display("[TB] FAIL accept_timeout: actual=0 expected=1 time=%0t", $time);
        end
    endtask

    task automatic waitIdle(input int limit);
        int t;
        t = 0;
        while (m_busy && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (m_busy) begin
            checks++; failures++;
            $display("[TB] FAIL idle_timeout: actual=busy expected=idle time=%0t", $time);
        end
    endtask

    task automatic waitCount(input int value);
        int t;
        t = 0;
        while (m_cnt != value && t < PERIOD + 4) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic directedCase(input string name, input int sp, input int me, input int k,
                                input int exp_duty, input int exp_sat);
        int start;
        start = upd_count;
        applyStimulus(sp, me, k);
        waitIdle(PERIOD + 16);
        @(posedge clk);
        #1;
        checkOutput({name, "_duty"}, int'(duty_cycle), exp_duty);
        checkOutput({name, "_sat"}, int'(saturated), exp_sat);
        checkOutput({name, "_model"}, m_duty, exp_duty);
        checkOutput({name, "_pulses"}, upd_count - start, 1);
    endtask

    initial begin
        int start;
        int t;
        #1 reset_n = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_duty", int'(duty_cycle), 0);
        checkOutput("reset_sat", int'(saturated), 0);
        checkOutput("reset_update", int'(duty_update), 0);
        checkOutput("reset_ready", int'(sample_ready), 0);
        #1 reset_n = 1'b1;

        $display("[TB] directed proportional updates");
`ifdef P_DUTY_SLEW_LIMIT_EN
        directedCase("step_up", 100, 60, 4, 16, 1);
        directedCase("step_down", 0, 200, 4, 0, 1);
        directedCase("full_up", 255, 0, 15, 16, 1);
`else
        directedCase("step_up", 100, 60, 4, 40, 0);
        directedCase("step_down", 0, 200, 4, 0, 1);
        directedCase("full_up", 255, 0, 15, 255, 1);
`endif

        @(negedge clk);
        #1 enable = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("disable_duty", int'(duty_cycle), 0);
        checkOutput("disable_sat", int'(saturated), 0);
        #1 enable = 1'b1;

        $display("[TB] sample offered while waiting for the boundary");
        waitCount(200);
        start = upd_count;
        applyStimulus(50, 40, 4);
        @(negedge clk);
        #1;
        setpoint = 8'd200; measurement = 8'd0; kp = 4'd15; sample_valid = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("ready_in_wait", int'(sample_ready), 0);
        t = 0;
        while (m_busy && t < PERIOD + 16) begin
            @(negedge clk);
            t++;
        end
        #1 sample_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("held_valid_duty", int'(duty_cycle), 10);
        checkOutput("held_valid_pulses", upd_count - start, 1);

        $display("[TB] reset during wait");
        waitCount(100);
        applyStimulus(120, 100, 4);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("pre_reset_duty", int'(duty_cycle), 10);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_duty", int'(duty_cycle), 0);
        checkOutput("midreset_update", int'(duty_update), 0);
        checkOutput("midreset_ready", int'(sample_ready), 0);
        #2 reset_n = 1'b1;
        start = upd_count;
        @(negedge clk);
        checkOutput("post_reset_ready", int'(sample_ready), 1);
        repeat (PERIOD + 16) @(negedge clk);
        checkOutput("post_reset_pulses", upd_count - start, 0);
        checkOutput("post_reset_duty", int'(duty_cycle), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            #1;
            enable       = ($urandom_range(0, 1999) != 0);
            sample_valid = ($urandom_range(0, 3) == 0);
            setpoint     = DUTY_W'($urandom_range(0, DUTY_MAX));
            measurement  = DUTY_W'($urandom_range(0, DUTY_MAX));
            kp           = KP_W'($urandom_range(0, (1 << KP_W) - 1));
        end
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish time=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/p_duty_controller.md
P_DUTY_CONTROLLER -- requirements
Module: p_duty_controller

Interface
REQ-001 SHALL have parameter DUTY_W, default 8: width of setpoint, measurement and duty_cycle.
REQ-002 SHALL have parameter KP_W, default 4: width of unsigned gain kp.
REQ-003 SHALL have parameter KP_SHIFT, default 2: arithmetic right shift applied to the gain product.
REQ-004 SHALL have parameter PERIOD_W, default 10: width of the PWM period counter.
REQ-005 SHALL have parameter MAX_STEP, default 16: maximum duty change per update when slew limiting is compiled in.
REQ-006 SHALL have ports, one per line:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  controller enable.
- sample_valid  input  1  measurement sample offered.
- sample_ready  output  1  controller can accept a sample.
- setpoint  input  DUTY_W  target value, unsigned.
- measurement  input  DUTY_W  measured value, unsigned.
- kp  input  KP_W  proportional gain, unsigned.
- duty_cycle  output  DUTY_W  registered duty command to the PWM generator.
- duty_update  output  1  one-cycle pulse when duty_cycle changes register value.
- saturated  output  1  last applied result was clamped.

Function
REQ-007 SHALL keep a free-running PERIOD_W-bit period counter, cleared by reset and wrapping to 0 after all-ones; boundary = counter all-ones.
REQ-008 SHALL implement the FSM states IDLE, CALC, CLAMP, WAIT_PERIOD and APPLY.
REQ-009 SHALL drive sample_ready high only in IDLE with enable high; a sample is accepted on sample_valid and sample_ready both high, capturing setpoint, measurement and kp.
REQ-010 SHALL transition IDLE->CALC on acceptance; in CALC, error = setpoint - measurement as (DUTY_W+1)-bit signed and product = error * kp at full width.
REQ-011 SHALL transition CALC->CLAMP in one cycle; in CLAMP, candidate = duty_cycle + (product >>> KP_SHIFT), saturated to [0, 2^DUTY_W-1], with the saturation flag captured.
REQ-012 SHALL transition CLAMP->WAIT_PERIOD; WAIT_PERIOD->APPLY only in a cycle where WAIT_PERIOD coincides with the boundary; a boundary during CALC or CLAMP is missed and the next one is used.
REQ-013 SHALL, in APPLY (one cycle), load duty_cycle with the candidate, update saturated, pulse duty_update (registered, high during the cycle after APPLY, even if the value is unchanged), then return to IDLE.
REQ-014 SHALL hold duty_cycle constant except in APPLY or on disable.
REQ-015 SHALL, when enable is low in any state: go to IDLE next cycle, drop the pending sample, clear duty_cycle and saturated to 0 and not pulse duty_update.
REQ-016 SHALL ignore sample_valid outside IDLE; offered data is not stored.

Reset
REQ-017 SHALL, on reset_n low, asynchronously set FSM=IDLE, period counter=0, duty_cycle=0, duty_update=0, saturated=0, captured operands=0; sample_ready is low while reset_n is low.
REQ-018 SHALL discard any in-flight computation on reset mid-operation, with no duty_update pulse.

Configuration
REQ-019 SHALL, with P_DUTY_SLEW_LIMIT_EN defined, clamp the CLAMP-stage change to +/-MAX_STEP relative to the current duty_cycle after range saturation, with saturated set also when the slew clamp acts.
REQ-020 SHALL, without P_DUTY_SLEW_LIMIT_EN defined, apply no slew limit and leave MAX_STEP unused.

Structure
REQ-021 SHALL place the FSM state enum and default width constants in shared package p_ctrl_pkg.
REQ-022 SHALL implement the saturating add and optional slew clamp as combinational sub-module duty_clamp.

Verification
REQ-023 SHALL cover: duty=0, sp=100, meas=60, kp=4 -> duty_cycle=40 one cycle after the next boundary, duty_update pulse once, saturated=0.
REQ-024 SHALL cover: sp=255, meas=0, kp=15 (no slew) -> duty_cycle=255, saturated=1.
REQ-025 SHALL cover: duty=40, sp=0, meas=200, kp=4 -> duty_cycle=0, saturated=1.
REQ-026 SHALL cover: with P_DUTY_SLEW_LIMIT_EN, duty=0, sp=100, meas=60, kp=4 -> duty_cycle=16, saturated=1.
REQ-027 SHALL cover: sample_valid held during WAIT_PERIOD -> sample_ready=0 and the second sample is not applied.
REQ-028 SHALL cover: reset_n pulsed low in WAIT_PERIOD -> duty_cycle=0 immediately, no duty_update, sample_ready=1 after release.
